// File: rtl/iter_divider_if.sv
// iter_divider_if: valid/ready operand and result channels of the iterative divider.
//   in_valid/in_ready/div_signed/x/y : operand request channel
//   flush                            : abandon the current operation or result
//   out_valid/out_ready/quotient/remainder : result channel
//   master drives requests and consumes results; slave is the divider.
interface iter_divider_if #(parameter int WIDTH = 32);
   logic             in_valid;
   logic             in_ready;
   logic             div_signed;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   modport master (output in_valid, div_signed, x, y, flush, out_ready,
                   input  in_ready, out_valid, quotient, remainder);
   modport slave  (input  in_valid, div_signed, x, y, flush, out_ready,
                   output in_ready, out_valid, quotient, remainder);
endinterface

// File: rtl/iter_divider.sv
// iter_divider: radix-2 restoring divider, one quotient bit per cycle, signed/unsigned.
//   clk   : clock, all state updates on its rising edge
//   reset : synchronous active-high reset
//   bus   : iter_divider_if slave (operand channel, flush, result channel)
module iter_divider #(parameter int WIDTH = 32) (
   input logic         clk,
   input logic         reset,
   iter_divider_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t           state;
   logic [WIDTH-1:0] a, b, r, qn, rn;
   logic [WIDTH:0]   sh, diff;
   logic             sx, sy, qb;
   logic [CW-1:0]    cnt;
   assign bus.in_ready = (state == IDLE) && !reset;
   // a holds the dividend bits still to be consumed at its top and collects
   // quotient bits at its bottom; r is the partial remainder.
   always_comb begin
      sh   = {r, a[WIDTH-1]};
      diff = sh - {1'b0, b};
      qb   = !diff[WIDTH];
      rn   = qb ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
      qn   = {a[WIDTH-2:0], qb};
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         cnt           <= '0;
         bus.out_valid <= 1'b0;
         bus.quotient  <= '0;
         bus.remainder <= '0;
      end else if (bus.flush) begin
         state         <= IDLE;
         bus.out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: if (bus.in_valid) begin
               sx  <= bus.div_signed && bus.x[WIDTH-1];
               sy  <= bus.div_signed && bus.y[WIDTH-1];
               a   <= (bus.div_signed && bus.x[WIDTH-1]) ? -bus.x : bus.x;
               b   <= (bus.div_signed && bus.y[WIDTH-1]) ? -bus.y : bus.y;
               r   <= '0;
               cnt <= '0;
               if (bus.y == '0) begin
                  // divide by zero completes immediately with the raw dividend
                  state         <= DONE;
                  bus.out_valid <= 1'b1;
                  bus.quotient  <= '1;
                  bus.remainder <= bus.x;
               end else begin
                  state <= CALC;
               end
            end
            CALC: begin
               a   <= qn;
               r   <= rn;
               cnt <= cnt + CW'(1);
               if (cnt == CW'(WIDTH - 1)) begin
                  state         <= DONE;
                  bus.out_valid <= 1'b1;
                  bus.quotient  <= (sx ^ sy) ? -qn : qn;
                  bus.remainder <= sx ? -rn : rn;
               end
            end
            DONE: if (bus.out_ready) begin
               state         <= IDLE;
               bus.out_valid <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_iter_divider.sv
// tb_iter_divider: table-driven check of iter_divider plus backpressure, flush and reset sequences.
module tb_iter_divider;
   logic clk = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;
   int   xfers = 0;
   iter_divider_if #(.WIDTH(32)) bus ();
   iter_divider #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
   always #5 clk = ~clk;
   always @(posedge clk) if (bus.out_valid && bus.out_ready) xfers++;
   typedef struct {
      logic        s;
      logic [31:0] x, y, q, r;
      int          lat;
   } vec_t;
   vec_t vecs[12];
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   // Accept one operation, wait for the result with out_ready=1 and check it.
   task automatic run_op(input vec_t v);
      int lat;
      @(negedge clk);
      chk("accept_ready", bus.in_ready, 1);
      bus.in_valid = 1'b1;
      bus.div_signed = v.s;
      bus.x = v.x;
      bus.y = v.y;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.div_signed = ~v.s;
      bus.x = $urandom;
      bus.y = $urandom;
      lat = 1;
      while (!bus.out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      chk("latency", lat, v.lat);
      chk("quotient", bus.quotient, v.q);
      chk("remainder", bus.remainder, v.r);
      chk("busy_ready", bus.in_ready, 0);
      @(negedge clk);
      chk("ready_after", bus.in_ready, 1);
      chk("valid_after", bus.out_valid, 0);
   endtask
   task automatic no_result(input int n, input string name);
      int seen = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (bus.out_valid) seen++;
      end
      chk(name, seen, 0);
   endtask
   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
   initial begin
      logic [31:0] hq, hr;
      int          x0;
      vecs[0]  = '{1'b0, 32'd100,      32'd7,          32'd14,         32'd2,          33};
      vecs[1]  = '{1'b1, 32'hFFFFFFF9, 32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   33};
      vecs[2]  = '{1'b1, 32'd7,        32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          33};
      vecs[3]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF,   32'h80000000,   32'd0,          33};
      vecs[4]  = '{1'b0, 32'h80000000, 32'hFFFFFFFF,   32'd0,          32'h80000000,   33};
      vecs[5]  = '{1'b0, 32'd5,        32'd0,          32'hFFFFFFFF,   32'd5,          1};
      vecs[6]  = '{1'b1, 32'd5,        32'd0,          32'hFFFFFFFF,   32'd5,          1};
      vecs[7]  = '{1'b0, 32'd9,        32'd3,          32'd3,          32'd0,          33};
      vecs[8]  = '{1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   33};
      vecs[9]  = '{1'b0, 32'hFFFFFFFF, 32'd1,          32'hFFFFFFFF,   32'd0,          33};
      vecs[10] = '{1'b1, 32'hFFFFFF9C, 32'd0,          32'hFFFFFFFF,   32'hFFFFFF9C,   1};
      vecs[11] = '{1'b0, 32'hFFFFFF9C, 32'd10,         32'd429496719,  32'd6,          33};
      reset = 1'b1;
      bus.in_valid = 1'b0;
      bus.div_signed = 1'b0;
      bus.x = '0;
      bus.y = '0;
      bus.flush = 1'b0;
      bus.out_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_in_ready", bus.in_ready, 0);
      chk("reset_out_valid", bus.out_valid, 0);
      chk("reset_quotient", bus.quotient, 0);
      chk("reset_remainder", bus.remainder, 0);
      reset = 1'b0;
      #1;
      chk("post_reset_ready", bus.in_ready, 1);
      foreach (vecs[i]) run_op(vecs[i]);
      // backpressure: result held with out_ready=0 while inputs churn
      @(negedge clk);
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1;
      bus.div_signed = 1'b0;
      bus.x = 32'd1000;
      bus.y = 32'd10;
      @(negedge clk);
      bus.in_valid = 1'b0;
      x0 = 0;
      while (!bus.out_valid && x0 < 100) begin
         @(negedge clk);
         x0++;
      end
      chk("bp_valid", bus.out_valid, 1);
      hq = bus.quotient;
      hr = bus.remainder;
      chk("bp_quotient", hq, 32'd100);
      chk("bp_remainder", hr, 32'd0);
      x0 = xfers;
      for (int i = 0; i < 10; i++) begin
         bus.in_valid = 1'b1;
         bus.div_signed = i[0];
         bus.x = $urandom;
         bus.y = $urandom;
         @(negedge clk);
         chk("bp_hold_q", bus.quotient, hq);
         chk("bp_hold_r", bus.remainder, hr);
         chk("bp_hold_valid", bus.out_valid, 1);
         chk("bp_hold_ready", bus.in_ready, 0);
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("bp_drop_valid", bus.out_valid, 0);
      chk("bp_ready", bus.in_ready, 1);
      @(negedge clk);
      chk("bp_one_xfer", xfers - x0, 1);
      // flush 10 cycles after accept, with a competing request
      bus.in_valid = 1'b1;
      bus.div_signed = 1'b0;
      bus.x = 32'd100;
      bus.y = 32'd7;
      @(negedge clk);
      bus.in_valid = 1'b0;
      no_result(9, "flush_pre");
      bus.flush = 1'b1;
      bus.in_valid = 1'b1;
      bus.x = 32'd9;
      bus.y = 32'd3;
      @(negedge clk);
      bus.flush = 1'b0;
      bus.in_valid = 1'b0;
      chk("flush_ready", bus.in_ready, 1);
      chk("flush_valid", bus.out_valid, 0);
      no_result(45, "flush_no_result");
      // reset 10 cycles after accept
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.x = 32'd100;
      bus.y = 32'd7;
      @(negedge clk);
      bus.in_valid = 1'b0;
      no_result(9, "reset_pre");
      reset = 1'b1;
      @(negedge clk);
      chk("mid_reset_ready", bus.in_ready, 0);
      chk("mid_reset_valid", bus.out_valid, 0);
      chk("mid_reset_q", bus.quotient, 0);
      chk("mid_reset_r", bus.remainder, 0);
      reset = 1'b0;
      no_result(45, "reset_no_result");
      run_op(vecs[7]);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/iter_divider.md
# iter_divider

Parametrised multi-cycle integer divider for the EX stage, succeeding the fixed 32-bit divider behind the ALU. It computes quotient and remainder with one radix-2 restoring step per cycle. Operands are taken and results returned over valid/ready handshakes, so the pipeline can stall on either side. Division by zero is detected on entry and completes early, and an in-flight operation can be flushed on an exception or branch cancel.

## Interface
- WIDTH, 32, operand and result width in bits (≥4, power of two not required)
- clk  input  1  clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operands and mode are valid this cycle
- in_ready  output  1  divider can accept; high only in IDLE and not in reset
- div_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled at accept
- x  input  WIDTH  dividend; sampled at accept
- y  input  WIDTH  divisor; sampled at accept
- flush  input  1  abandon current operation or result
- out_valid  output  1  quotient/remainder valid
- out_ready  input  1  consumer takes result this cycle
- quotient  output  WIDTH  quotient, truncated toward zero
- remainder  output  WIDTH  remainder, sign of dividend

## Operation
- States: IDLE, CALC, DONE. Step counter width is clog2(WIDTH+1).
- Accept occurs when in_valid & in_ready & ~flush. On accept, the block latches the operand magnitudes, sign flags (x[WIDTH-1] and y[WIDTH-1] when signed, else 0) and a zero-divisor flag, then clears the counter.
- IDLE→CALC on accept with y≠0. IDLE→DONE on accept with y==0.
- Each CALC cycle does one restoring step: shift the partial remainder left by one bit, bringing in the next dividend MSB. Trial-subtract |y|. The quotient bit is 1 if there is no borrow, in which case the difference is kept.
- After step WIDTH-1, CALC→DONE. Sign fix-up is applied when the result registers are loaded:
  - quotient is negated if the two sign flags differ;
  - remainder is negated if the dividend sign flag is set.
- Overflow case (signed MIN / -1) falls out of WIDTH-bit truncation: quotient = MIN, remainder = 0. No special path.
- Divide by zero, either mode: quotient = all ones, remainder = x as latched.
- DONE holds out_valid=1 with stable quotient and remainder until out_ready is 1, then goes to IDLE.
- Flush has priority over everything except reset. In any state the next state is IDLE, out_valid drops next cycle, and no accept occurs in a flush cycle.
- Inputs x, y and div_signed are ignored outside the accept cycle.

## Timing
- Reset values are applied at the clock edge where reset is high:
  - state IDLE, counter 0, out_valid 0, quotient 0, remainder 0;
  - in_ready is 0 while reset is high and 1 in the first cycle after.
- A reset mid-operation discards all state; no result is ever produced for that operation.
- Latency with accept in cycle T:
  - nonzero divisor: out_valid first high in cycle T+WIDTH+1;
  - zero divisor: out_valid first high in cycle T+1.
- in_ready is low from T+1 until the cycle after the result handshake. This gives one idle cycle minimum between result and next accept, and no accept in the same cycle as the result handshake.
- out_valid is registered. in_ready is combinational from state and reset only, with no path from in_valid.
- Flush asserted in cycle F gives IDLE and in_ready=1 in cycle F+1.

## Test plan
- Unsigned, WIDTH=32: x=100, y=7, accept in cycle T. Requires quotient=14, remainder=2, out_valid rising in cycle T+33, out_ready held 1, in_ready back to 1 in T+34.
- Signed divisions:
  - -7/2 (x=0xFFFFFFF9, y=2) requires quotient=0xFFFFFFFD, remainder=0xFFFFFFFF;
  - 7/-2 requires quotient=0xFFFFFFFD, remainder=1.
- x=0x80000000, y=0xFFFFFFFF:
  - signed requires quotient=0x80000000, remainder=0;
  - unsigned requires quotient=0, remainder=0x80000000.
- Divide by zero: x=5, y=0, either mode, requires quotient=0xFFFFFFFF, remainder=5, out_valid in cycle T+1.
- Backpressure and input isolation: hold out_ready=0 for 10 cycles after out_valid and change x/y every cycle. Results must stay stable, in_ready must stay 0, and exactly one result transfers on out_ready=1.
- Flush and reset:
  - flush 10 cycles after accept, together with in_valid=1: no out_valid ever, no accept in the flush cycle, in_ready=1 next cycle;
  - repeat with reset instead of flush: outputs are 0 and the next operation 9/3 returns quotient=3, remainder=0.
